// File: rtl/equiv_pkg.sv
// Purpose: shared types, sweep-mode encodings and the index-to-stimulus
//          code conversion for the exhaustive equivalence checker.
// Contents:
//   state_e  - checker FSM states
//   MODE_*   - sweep order encodings (mode value 3 falls back to binary-up)
//   code_of  - maps a sweep index to the stimulus vector for a given order
package equiv_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_e;

  localparam logic [1:0] MODE_UP   = 2'd0;
  localparam logic [1:0] MODE_GRAY = 2'd1;
  localparam logic [1:0] MODE_DOWN = 2'd2;

  // Widest stimulus the conversion supports; callers truncate to IN_W.
  localparam int CODE_W = 32;

  // Callers pass the index zero-extended to CODE_W and keep the low bits,
  // so the Gray shift and the down inversion behave as if done at IN_W.
  function automatic logic [CODE_W-1:0] code_of(input logic [CODE_W-1:0] idx,
                                                input logic [1:0]        mode);
    case (mode)
      MODE_GRAY: code_of = idx ^ (idx >> 1);
      MODE_DOWN: code_of = ~idx;
      default:   code_of = idx;
    endcase
  endfunction

endpackage

// File: rtl/equiv_vec_seq.sv
// Purpose: stimulus sequencer. Walks the sweep index 0 .. 2^IN_W-1, holds
//          each vector for SETTLE+1 cycles and drives the registered
//          stimulus bus in the latched sweep order.
// Ports:
//   clk, rst_n  - clock, asynchronous active-low reset
//   load_i      - start accepted this edge: index 0, hold SETTLE, latch mode
//   adv_i       - sweep advancing this edge (RUN and not aborting)
//   mode_i      - sweep order sampled on load_i
//   vec_o       - registered stimulus vector
//   cmp_o       - hold counter exhausted: this edge is a compare edge
//   last_o      - current vector is the final one of the sweep
module equiv_vec_seq
  import equiv_pkg::*;
#(
  parameter int IN_W   = 4,
  parameter int SETTLE = 1
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            load_i,
  input  logic            adv_i,
  input  logic [1:0]      mode_i,
  output logic [IN_W-1:0] vec_o,
  output logic            cmp_o,
  output logic            last_o
);

  localparam int HOLD_W = (SETTLE < 1) ? 1 : $clog2(SETTLE + 1);
  localparam logic [HOLD_W-1:0] HOLD_INIT = HOLD_W'(SETTLE);
  // One spare index bit keeps the terminal value distinct from a wrap.
  localparam logic [IN_W:0] IDX_LAST = {1'b0, {IN_W{1'b1}}};

  logic [IN_W:0]     idx_q, idx_d, idx_inc;
  logic [HOLD_W-1:0] hold_q, hold_d;
  logic [1:0]        mode_q, mode_d;
  logic [IN_W-1:0]   vec_q, vec_d;
  logic [IN_W-1:0]   code_idx;
  logic [1:0]        code_mode;

  assign idx_inc = idx_q + (IN_W + 1)'(1);
  assign cmp_o   = (hold_q == '0);
  assign last_o  = (idx_q == IDX_LAST);
  assign vec_o   = vec_q;

  // On load the new mode is not yet registered, so convert with mode_i.
  assign code_idx  = load_i ? '0 : idx_inc[IN_W-1:0];
  assign code_mode = load_i ? mode_i : mode_q;

  always_comb begin
    idx_d  = idx_q;
    hold_d = hold_q;
    mode_d = mode_q;
    vec_d  = vec_q;
    if (load_i) begin
      idx_d  = '0;
      hold_d = HOLD_INIT;
      mode_d = mode_i;
      vec_d  = IN_W'(code_of(CODE_W'(code_idx), code_mode));
    end else if (adv_i) begin
      if (hold_q != '0) begin
        hold_d = hold_q - HOLD_W'(1);
      end else if (!last_o) begin
        idx_d  = idx_inc;
        hold_d = HOLD_INIT;
        vec_d  = IN_W'(code_of(CODE_W'(code_idx), code_mode));
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      idx_q  <= '0;
      hold_q <= '0;
      mode_q <= MODE_UP;
      vec_q  <= '0;
    end else begin
      idx_q  <= idx_d;
      hold_q <= hold_d;
      mode_q <= mode_d;
      vec_q  <= vec_d;
    end
  end

endmodule

// File: rtl/equiv_checker.sv
// Purpose: exhaustive equivalence checker for two combinational functions
//          sharing one stimulus bus. Sweeps every IN_W-bit vector, compares
//          f_dut against f_ref after a settle window, and reports a
//          saturating mismatch count, the first failing vector and pass/fail.
// Ports:
//   clk, rst_n        - clock, asynchronous active-low reset
//   start             - begin a sweep (honoured in IDLE/DONE only)
//   abort             - stop a sweep (honoured in RUN only)
//   mode              - sweep order: 0 up, 1 Gray, 2 down, 3 up
//   vec_out           - registered stimulus to both implementations
//   f_dut, f_ref      - outputs of the two implementations
//   busy, done, pass  - sweep status; done/pass hold until the next start
//   mismatch_cnt      - saturating count of failing compares
//   first_fail_*      - valid flag, vector and XOR difference of the first fail
//
// state | meaning
// IDLE  | reset or aborted; waiting for start
// RUN   | sweep in progress
// DONE  | sweep finished; results held until the next start
module equiv_checker
  import equiv_pkg::*;
#(
  parameter int IN_W   = 4,
  parameter int OUT_W  = 1,
  parameter int SETTLE = 1,
  parameter int CNT_W  = 16
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic             abort,
  input  logic [1:0]       mode,
  output logic [IN_W-1:0]  vec_out,
  input  logic [OUT_W-1:0] f_dut,
  input  logic [OUT_W-1:0] f_ref,
  output logic             busy,
  output logic             done,
  output logic             pass,
  output logic [CNT_W-1:0] mismatch_cnt,
  output logic             first_fail_valid,
  output logic [IN_W-1:0]  first_fail_vec,
  output logic [OUT_W-1:0] first_fail_diff
);

  state_e           state_q;
  logic             busy_q, done_q, pass_q;
  logic [CNT_W-1:0] cnt_q;
  logic             ff_valid_q;
  logic [IN_W-1:0]  ff_vec_q;
  logic [OUT_W-1:0] ff_diff_q;

  logic             start_acc, run_en;
  logic             seq_cmp, seq_last;
  logic [OUT_W-1:0] diff;
  logic             neq;
  logic [CNT_W-1:0] cnt_inc, cnt_nxt;

  // Start beats abort outside RUN; abort beats the compare inside RUN.
  assign start_acc = (state_q != RUN) && start;
  assign run_en    = (state_q == RUN) && !abort;

  assign diff    = f_dut ^ f_ref;
  assign neq     = |diff;
  assign cnt_inc = (cnt_q == '1) ? cnt_q : cnt_q + CNT_W'(1);
  // Count as it stands after this compare; pass must include the last one.
  assign cnt_nxt = neq ? cnt_inc : cnt_q;

  equiv_vec_seq #(
    .IN_W  (IN_W),
    .SETTLE(SETTLE)
  ) u_seq (
    .clk   (clk),
    .rst_n (rst_n),
    .load_i(start_acc),
    .adv_i (run_en),
    .mode_i(mode),
    .vec_o (vec_out),
    .cmp_o (seq_cmp),
    .last_o(seq_last)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= IDLE;
      busy_q     <= 1'b0;
      done_q     <= 1'b0;
      pass_q     <= 1'b0;
      cnt_q      <= '0;
      ff_valid_q <= 1'b0;
      ff_vec_q   <= '0;
      ff_diff_q  <= '0;
    end else begin
      case (state_q)
        IDLE, DONE: begin
          if (start) begin
            state_q    <= RUN;
            busy_q     <= 1'b1;
            done_q     <= 1'b0;
            pass_q     <= 1'b0;
            cnt_q      <= '0;
            ff_valid_q <= 1'b0;
            ff_vec_q   <= '0;
            ff_diff_q  <= '0;
          end
        end
        RUN: begin
          if (abort) begin
            // Partial results stay visible for debug after an abort.
            state_q <= IDLE;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
            pass_q  <= 1'b0;
          end else if (seq_cmp) begin
            cnt_q <= cnt_nxt;
            if (neq && !ff_valid_q) begin
              ff_valid_q <= 1'b1;
              ff_vec_q   <= vec_out;
              ff_diff_q  <= diff;
            end
            if (seq_last) begin
              state_q <= DONE;
              busy_q  <= 1'b0;
              done_q  <= 1'b1;
              pass_q  <= (cnt_nxt == '0);
            end
          end
        end
        default: begin
          state_q <= IDLE;
          busy_q  <= 1'b0;
          done_q  <= 1'b0;
          pass_q  <= 1'b0;
        end
      endcase
    end
  end

  assign busy             = busy_q;
  assign done             = done_q;
  assign pass             = pass_q;
  assign mismatch_cnt     = cnt_q;
  assign first_fail_valid = ff_valid_q;
  assign first_fail_vec   = ff_vec_q;
  assign first_fail_diff  = ff_diff_q;

endmodule

// File: tb/tb_equiv_checker.sv
// Directed bench for equiv_checker. Two instances share clock, reset and
// control: u1 uses the default widths (OUT_W=1, CNT_W=16), u2 uses OUT_W=2
// and CNT_W=3 for the multi-bit difference and saturation cases. Each
// instance is fed by a bench-side reference function and a "DUT" function
// with selectable injected errors.
module tb_equiv_checker;

  logic clk = 1'b0;
  logic rst_n = 1'b1;
  logic start = 1'b0;
  logic abort = 1'b0;
  logic [1:0] mode = 2'd0;

  logic [3:0]  vec1, ffvec1;
  logic        f_dut1, f_ref1;
  logic        busy1, done1, pass1, ffv1, ffdiff1;
  logic [15:0] cnt1;

  logic [3:0] vec2, ffvec2;
  logic [1:0] f_dut2, f_ref2, ffdiff2;
  logic       busy2, done2, pass2, ffv2;
  logic [2:0] cnt2;

  int err1 = 0;
  int err2 = 0;
  int n_chk = 0;
  int n_fail = 0;

  always #5 clk = ~clk;

  always_comb begin
    f_ref1 = ^vec1;
    f_dut1 = f_ref1;
    case (err1)
      1: if (vec1 == 4'b1011) f_dut1 = ~f_ref1;
      2: if (vec1 == 4'b0000) f_dut1 = ~f_ref1;
      3: f_dut1 = ~f_ref1;
      default: ;
    endcase
  end

  always_comb begin
    f_ref2 = {vec2[3] & vec2[0], ^vec2};
    f_dut2 = f_ref2;
    case (err2)
      1: if (vec2 == 4'b1011) f_dut2 = f_ref2 ^ 2'b10;
      3: f_dut2 = ~f_ref2;
      default: ;
    endcase
  end

  equiv_checker #(.IN_W(4), .OUT_W(1), .SETTLE(1), .CNT_W(16)) u1 (
    .clk(clk), .rst_n(rst_n), .start(start), .abort(abort), .mode(mode),
    .vec_out(vec1), .f_dut(f_dut1), .f_ref(f_ref1),
    .busy(busy1), .done(done1), .pass(pass1), .mismatch_cnt(cnt1),
    .first_fail_valid(ffv1), .first_fail_vec(ffvec1), .first_fail_diff(ffdiff1)
  );

  equiv_checker #(.IN_W(4), .OUT_W(2), .SETTLE(1), .CNT_W(3)) u2 (
    .clk(clk), .rst_n(rst_n), .start(start), .abort(abort), .mode(mode),
    .vec_out(vec2), .f_dut(f_dut2), .f_ref(f_ref2),
    .busy(busy2), .done(done2), .pass(pass2), .mismatch_cnt(cnt2),
    .first_fail_valid(ffv2), .first_fail_vec(ffvec2), .first_fail_diff(ffdiff2)
  );

  // Start pulse spans accepting edge E; returns at the negedge after E.
  task automatic do_start();
    @(negedge clk) start = 1'b1;
    @(negedge clk) start = 1'b0;
  endtask

  task automatic test_reset();
    #2 rst_n = 1'b0;
    #1;
    n_chk++; if (busy1 !== 1'b0) begin n_fail++; $display("FAIL rst_busy: got %0b want 0", busy1); end
    n_chk++; if (done1 !== 1'b0) begin n_fail++; $display("FAIL rst_done: got %0b want 0", done1); end
    n_chk++; if (pass1 !== 1'b0) begin n_fail++; $display("FAIL rst_pass: got %0b want 0", pass1); end
    n_chk++; if (cnt1 !== 16'd0) begin n_fail++; $display("FAIL rst_cnt: got %0d want 0", cnt1); end
    n_chk++; if (ffv1 !== 1'b0) begin n_fail++; $display("FAIL rst_ffv: got %0b want 0", ffv1); end
    n_chk++; if (vec1 !== 4'd0) begin n_fail++; $display("FAIL rst_vec: got %0h want 0", vec1); end
    n_chk++; if (ffdiff2 !== 2'd0) begin n_fail++; $display("FAIL rst_ffdiff2: got %0h want 0", ffdiff2); end
    @(negedge clk) rst_n = 1'b1;
    repeat (2) @(negedge clk);
  endtask

  task automatic test_up_identical();
    err1 = 0; err2 = 0; mode = 2'd0;
    do_start();
    n_chk++; if (busy1 !== 1'b1) begin n_fail++; $display("FAIL up_busy: got %0b want 1", busy1); end
    for (int k = 0; k < 16; k++) begin
      n_chk++; if (vec1 !== 4'(k)) begin n_fail++; $display("FAIL up_vec_a k=%0d: got %0h want %0h", k, vec1, k); end
      @(negedge clk);
      n_chk++; if (vec1 !== 4'(k)) begin n_fail++; $display("FAIL up_vec_b k=%0d: got %0h want %0h", k, vec1, k); end
      if (k == 15) begin
        n_chk++; if (done1 !== 1'b0) begin n_fail++; $display("FAIL up_done_early: got %0b want 0", done1); end
      end
      @(negedge clk);
    end
    n_chk++; if (done1 !== 1'b1) begin n_fail++; $display("FAIL up_done: got %0b want 1", done1); end
    n_chk++; if (busy1 !== 1'b0) begin n_fail++; $display("FAIL up_busy_end: got %0b want 0", busy1); end
    n_chk++; if (pass1 !== 1'b1) begin n_fail++; $display("FAIL up_pass: got %0b want 1", pass1); end
    n_chk++; if (cnt1 !== 16'd0) begin n_fail++; $display("FAIL up_cnt: got %0d want 0", cnt1); end
    n_chk++; if (ffv1 !== 1'b0) begin n_fail++; $display("FAIL up_ffv: got %0b want 0", ffv1); end
    n_chk++; if (pass2 !== 1'b1) begin n_fail++; $display("FAIL up_pass2: got %0b want 1", pass2); end
    repeat (3) @(negedge clk);
    n_chk++; if (done1 !== 1'b1) begin n_fail++; $display("FAIL up_done_hold: got %0b want 1", done1); end
  endtask

  task automatic test_single_mismatch();
    err1 = 1; err2 = 1; mode = 2'd0;
    do_start();
    n_chk++; if (done1 !== 1'b0) begin n_fail++; $display("FAIL sm_done_clr: got %0b want 0", done1); end
    repeat (32) @(negedge clk);
    n_chk++; if (done1 !== 1'b1) begin n_fail++; $display("FAIL sm_done: got %0b want 1", done1); end
    n_chk++; if (pass1 !== 1'b0) begin n_fail++; $display("FAIL sm_pass: got %0b want 0", pass1); end
    n_chk++; if (cnt1 !== 16'd1) begin n_fail++; $display("FAIL sm_cnt: got %0d want 1", cnt1); end
    n_chk++; if (ffv1 !== 1'b1) begin n_fail++; $display("FAIL sm_ffv: got %0b want 1", ffv1); end
    n_chk++; if (ffvec1 !== 4'b1011) begin n_fail++; $display("FAIL sm_ffvec: got %0b want 1011", ffvec1); end
    n_chk++; if (ffdiff1 !== 1'b1) begin n_fail++; $display("FAIL sm_ffdiff: got %0b want 1", ffdiff1); end
    n_chk++; if (cnt2 !== 3'd1) begin n_fail++; $display("FAIL sm_cnt2: got %0d want 1", cnt2); end
    n_chk++; if (ffvec2 !== 4'b1011) begin n_fail++; $display("FAIL sm_ffvec2: got %0b want 1011", ffvec2); end
    n_chk++; if (ffdiff2 !== 2'b10) begin n_fail++; $display("FAIL sm_ffdiff2: got %0b want 10", ffdiff2); end
  endtask

  task automatic test_gray();
    logic [3:0] exp_v, prev_v;
    err1 = 0; err2 = 0; mode = 2'd1;
    prev_v = 4'd0;
    do_start();
    for (int k = 0; k < 16; k++) begin
      exp_v = 4'(k ^ (k >> 1));
      n_chk++; if (vec1 !== exp_v) begin n_fail++; $display("FAIL gray_vec k=%0d: got %0b want %0b", k, vec1, exp_v); end
      if (k > 0) begin
        n_chk++; if ($countones(vec1 ^ prev_v) != 1) begin n_fail++; $display("FAIL gray_step k=%0d: got %0b after %0b want one-bit change", k, vec1, prev_v); end
      end
      prev_v = vec1;
      repeat (2) @(negedge clk);
    end
    n_chk++; if (done1 !== 1'b1) begin n_fail++; $display("FAIL gray_done: got %0b want 1", done1); end
    n_chk++; if (pass1 !== 1'b1) begin n_fail++; $display("FAIL gray_pass: got %0b want 1", pass1); end
  endtask

  task automatic test_down();
    err1 = 2; err2 = 0; mode = 2'd2;
    do_start();
    n_chk++; if (vec1 !== 4'b1111) begin n_fail++; $display("FAIL down_first: got %0b want 1111", vec1); end
    repeat (31) @(negedge clk);
    n_chk++; if (vec1 !== 4'b0000) begin n_fail++; $display("FAIL down_last: got %0b want 0000", vec1); end
    n_chk++; if (done1 !== 1'b0) begin n_fail++; $display("FAIL down_done_early: got %0b want 0", done1); end
    n_chk++; if (cnt1 !== 16'd0) begin n_fail++; $display("FAIL down_cnt_early: got %0d want 0", cnt1); end
    @(negedge clk);
    n_chk++; if (done1 !== 1'b1) begin n_fail++; $display("FAIL down_done: got %0b want 1", done1); end
    n_chk++; if (pass1 !== 1'b0) begin n_fail++; $display("FAIL down_pass: got %0b want 0", pass1); end
    n_chk++; if (cnt1 !== 16'd1) begin n_fail++; $display("FAIL down_cnt: got %0d want 1", cnt1); end
    n_chk++; if (ffvec1 !== 4'b0000) begin n_fail++; $display("FAIL down_ffvec: got %0b want 0000", ffvec1); end
    n_chk++; if (ffdiff1 !== 1'b1) begin n_fail++; $display("FAIL down_ffdiff: got %0b want 1", ffdiff1); end
  endtask

  // mode 3 must behave as binary-up; start mid-sweep must be ignored.
  task automatic test_abort();
    err1 = 3; err2 = 0; mode = 2'd3;
    do_start();
    repeat (4) @(negedge clk);
    start = 1'b1;
    @(negedge clk) start = 1'b0;
    n_chk++; if (vec1 !== 4'd2) begin n_fail++; $display("FAIL ab_restart_vec: got %0h want 2", vec1); end
    n_chk++; if (busy1 !== 1'b1) begin n_fail++; $display("FAIL ab_restart_busy: got %0b want 1", busy1); end
    @(negedge clk);
    n_chk++; if (vec1 !== 4'd3) begin n_fail++; $display("FAIL ab_vec3: got %0h want 3", vec1); end
    repeat (3) @(negedge clk);
    n_chk++; if (cnt1 !== 16'd4) begin n_fail++; $display("FAIL ab_cnt_pre: got %0d want 4", cnt1); end
    abort = 1'b1;
    @(negedge clk) abort = 1'b0;
    n_chk++; if (busy1 !== 1'b0) begin n_fail++; $display("FAIL ab_busy: got %0b want 0", busy1); end
    n_chk++; if (done1 !== 1'b0) begin n_fail++; $display("FAIL ab_done: got %0b want 0", done1); end
    n_chk++; if (pass1 !== 1'b0) begin n_fail++; $display("FAIL ab_pass: got %0b want 0", pass1); end
    n_chk++; if (cnt1 !== 16'd4) begin n_fail++; $display("FAIL ab_cnt: got %0d want 4", cnt1); end
    n_chk++; if (ffv1 !== 1'b1) begin n_fail++; $display("FAIL ab_ffv: got %0b want 1", ffv1); end
    n_chk++; if (ffvec1 !== 4'd0) begin n_fail++; $display("FAIL ab_ffvec: got %0h want 0", ffvec1); end
    n_chk++; if (vec1 !== 4'd4) begin n_fail++; $display("FAIL ab_vec_hold: got %0h want 4", vec1); end
    repeat (4) @(negedge clk);
    n_chk++; if (busy1 !== 1'b0) begin n_fail++; $display("FAIL ab_idle_busy: got %0b want 0", busy1); end
    n_chk++; if (vec1 !== 4'd4) begin n_fail++; $display("FAIL ab_idle_vec: got %0h want 4", vec1); end
  endtask

  task automatic test_saturate();
    err1 = 0; err2 = 3; mode = 2'd0;
    do_start();
    repeat (32) @(negedge clk);
    n_chk++; if (done2 !== 1'b1) begin n_fail++; $display("FAIL sat_done2: got %0b want 1", done2); end
    n_chk++; if (cnt2 !== 3'd7) begin n_fail++; $display("FAIL sat_cnt2: got %0d want 7", cnt2); end
    n_chk++; if (ffvec2 !== 4'b0000) begin n_fail++; $display("FAIL sat_ffvec2: got %0b want 0000", ffvec2); end
    n_chk++; if (ffdiff2 !== 2'b11) begin n_fail++; $display("FAIL sat_ffdiff2: got %0b want 11", ffdiff2); end
    n_chk++; if (pass2 !== 1'b0) begin n_fail++; $display("FAIL sat_pass2: got %0b want 0", pass2); end
    n_chk++; if (pass1 !== 1'b1) begin n_fail++; $display("FAIL sat_pass1: got %0b want 1", pass1); end
  endtask

  // Start and abort together in DONE: start wins. Then reset mid-sweep.
  task automatic test_reset_mid();
    err1 = 0; err2 = 3; mode = 2'd0;
    @(negedge clk) begin start = 1'b1; abort = 1'b1; end
    @(negedge clk) begin start = 1'b0; abort = 1'b0; end
    n_chk++; if (busy1 !== 1'b1) begin n_fail++; $display("FAIL sa_busy: got %0b want 1", busy1); end
    n_chk++; if (cnt2 !== 3'd0) begin n_fail++; $display("FAIL sa_cnt2_clr: got %0d want 0", cnt2); end
    n_chk++; if (ffv2 !== 1'b0) begin n_fail++; $display("FAIL sa_ffv2_clr: got %0b want 0", ffv2); end
    repeat (11) @(negedge clk);
    n_chk++; if (cnt2 !== 3'd5) begin n_fail++; $display("FAIL rm_cnt2_pre: got %0d want 5", cnt2); end
    rst_n = 1'b0;
    #1;
    n_chk++; if (busy1 !== 1'b0) begin n_fail++; $display("FAIL rm_busy: got %0b want 0", busy1); end
    n_chk++; if (vec1 !== 4'd0) begin n_fail++; $display("FAIL rm_vec: got %0h want 0", vec1); end
    n_chk++; if (cnt2 !== 3'd0) begin n_fail++; $display("FAIL rm_cnt2: got %0d want 0", cnt2); end
    n_chk++; if (ffv2 !== 1'b0) begin n_fail++; $display("FAIL rm_ffv2: got %0b want 0", ffv2); end
    @(negedge clk) rst_n = 1'b1;
    repeat (40) @(negedge clk);
    n_chk++; if (done1 !== 1'b0) begin n_fail++; $display("FAIL rm_no_done: got %0b want 0", done1); end
    err2 = 0;
    do_start();
    repeat (32) @(negedge clk);
    n_chk++; if (done1 !== 1'b1) begin n_fail++; $display("FAIL rm_fresh_done: got %0b want 1", done1); end
    n_chk++; if (pass1 !== 1'b1) begin n_fail++; $display("FAIL rm_fresh_pass: got %0b want 1", pass1); end
    n_chk++; if (pass2 !== 1'b1) begin n_fail++; $display("FAIL rm_fresh_pass2: got %0b want 1", pass2); end
    n_chk++; if (cnt2 !== 3'd0) begin n_fail++; $display("FAIL rm_fresh_cnt2: got %0d want 0", cnt2); end
  endtask

  initial begin
    test_reset();
    test_up_identical();
    test_single_mismatch();
    test_gray();
    test_down();
    test_abort();
    test_saturate();
    test_reset_mid();
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule

// File: doc/equiv_checker.md
Name: equiv_checker

Overview:
- Synthesisable, parametrised successor to the exhaustive toggle-stimulus bench used for the combinational homework problems.
- Drives every IN_W-bit input vector onto a shared stimulus bus feeding two combinational implementations: the DUT and the reference solution.
- Compares their OUT_W-bit outputs after a programmable settle time, then reports mismatch count, first failing vector and pass/fail.
- Supports binary-up, Gray and binary-down sweep orders.

Parameters:
- IN_W, 4: stimulus width; sweep covers 2^IN_W vectors.
- OUT_W, 1: width of the compared function outputs.
- SETTLE, 1: extra hold cycles per vector before sampling; legal range ≥ 1.
- CNT_W, 16: mismatch counter width.

Ports:
- clk  in  1  single clock, rising edge.
- rst_n  in  1  asynchronous, active-low reset.
- start  in  1  begin a sweep; sampled in IDLE/DONE only.
- abort  in  1  terminate a sweep; sampled in RUN only.
- mode  in  2  sweep order: 0 up, 1 Gray, 2 down, 3 treated as up; latched at start.
- vec_out  out  IN_W  registered stimulus to both implementations.
- f_dut  in  OUT_W  DUT output.
- f_ref  in  OUT_W  reference output.
- busy  out  1  sweep in progress.
- done  out  1  sweep completed; held until next start.
- pass  out  1  done and zero mismatches.
- mismatch_cnt  out  CNT_W  saturating mismatch count.
- first_fail_valid  out  1  at least one mismatch recorded.
- first_fail_vec  out  IN_W  vec_out at first mismatch.
- first_fail_diff  out  OUT_W  f_dut XOR f_ref at first mismatch.

Behaviour:
- Reset (asynchronous, rst_n low): state IDLE; all outputs 0; idx 0; hold counter 0.
- States:
  - IDLE: start → RUN.
  - RUN: sweep in progress; exit on last compare or abort.
  - DONE: start → RUN.
- start accepted at edge E:
  - idx=0, hold=SETTLE, mode latched.
  - mismatch_cnt, first_fail_* and done/pass cleared.
  - busy=1; vec_out = code(0) from edge E.
- vec_out = code(idx):
  - up: idx.
  - Gray: idx ^ (idx>>1).
  - down: ~idx.
- Each vector is held SETTLE+1 cycles. In RUN, each edge with hold>0 decrements hold.
- Edge with hold==0 (compare edge):
  - Sample f_dut vs f_ref.
  - On inequality: mismatch_cnt+1, saturating at 2^CNT_W−1.
  - First inequality only: first_fail_valid=1, first_fail_vec=vec_out, first_fail_diff=f_dut^f_ref; never overwritten later in the sweep.
  - If idx == 2^IN_W−1: → DONE, busy=0, done=1, pass = (final count == 0), including the mismatch from this same edge.
  - Otherwise: idx+1, hold=SETTLE, vec_out updates at that edge.
- Vector k (0-based) is compared at edge E+(k+1)(SETTLE+1). done rises at edge E+2^IN_W·(SETTLE+1).
- start during RUN: ignored.
- abort during RUN: → IDLE at next edge; busy=0, done=0, pass=0. Counters and first_fail_* retain their partial values; vec_out holds.
- abort and compare edge coincide: abort wins; no DONE.
- start and abort both high in IDLE/DONE: start wins.
- idx is IN_W+1 bits internally so the terminal compare is unambiguous; no wrap past the last vector.
- rst_n low mid-sweep: immediate return to reset values; no done.

Decomposition:
- Package equiv_pkg:
  - state enum IDLE/RUN/DONE.
  - mode constants MODE_UP=0, MODE_GRAY=1, MODE_DOWN=2.
  - function code_of(idx, mode).
- Sub-module equiv_vec_seq (parametrised IN_W, SETTLE): idx/hold counters, code conversion and vec_out register. Outputs a compare strobe and last flag.
- Top equiv_checker: FSM, mismatch counter and first-fail capture.

Test Plan (IN_W=4, OUT_W=1, SETTLE=1, CNT_W=16 unless noted):
- Identical functions, mode up, start at edge 0 → vec_out 0..15, each held 2 cycles; done=1 after edge 32; pass=1; mismatch_cnt=0; first_fail_valid=0.
- f_dut = f_ref ^ (vec==4'b1011) → mismatch_cnt=1, first_fail_vec=1011, first_fail_diff=1, pass=0. With OUT_W=2 and bit1 flipped: diff=2'b10.
- mode Gray → vec_out sequence 0000,0001,0011,0010,0110,…,1000. Consecutive vectors differ in exactly one bit; done after edge 32.
- mode down → first vec_out 1111, last 0000; f_dut forced wrong only at 0000 → mismatch on the edge-32 compare, done=1, pass=0.
- abort pulsed at edge 10 → busy=0, done=0 from edge 10; state IDLE; partial mismatch_cnt retained. start during RUN → no restart, sweep timing unchanged.
- CNT_W=3, f_dut = ~f_ref → mismatch_cnt saturates at 7; first_fail_vec=0000. rst_n low at edge 12 → all outputs 0 immediately; a fresh start completes normally.
